instruction_encoder: RTL

- Inverse of the immediate decoder: packs opcode, register, funct and 32-bit immediate fields into a 32-bit RV32I instruction word.
- Bit placement of the immediate in each format (I/S/B/U/J) is exactly the inverse of the decode rules.
- Used by the self-test instruction injector and testbench stimulus generators to feed instruction memory.
- Valid/ready streaming block: one registered output stage plus a one-entry skid buffer. Flags immediates that are out of range or misaligned.

---
 rtl/instruction_encoder.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/instruction_encoder.sv
// RV32I instruction encoder: packs opcode/register/funct/immediate fields into a word behind a
// valid/ready output register with a one-entry skid buffer. Optional ENCODER_STATS_EN adds transfer/error counters.
module instruction_encoder #(
  parameter int INSTRUCTION_SIZE = 32,
  parameter int IMMEDIATE_SIZE   = 32
`ifdef ENCODER_STATS_EN
  ,
  parameter int COUNT_WIDTH      = 16
`endif
) (
  input  logic                        Clock,
  input  logic                        ResetN,
  input  logic                        InValid,
  output logic                        InReady,
  input  logic [2:0]                  Format,
  input  logic [6:0]                  Opcode,
  input  logic [4:0]                  Rd,
  input  logic [4:0]                  Rs1,
  input  logic [4:0]                  Rs2,
  input  logic [2:0]                  Funct3,
  input  logic [6:0]                  Funct7,
  input  logic [IMMEDIATE_SIZE-1:0]   Immediate,
  output logic                        OutValid,
  input  logic                        OutReady,
  output logic [INSTRUCTION_SIZE-1:0] Instruction,
  output logic                        EncError
`ifdef ENCODER_STATS_EN
  ,
  input  logic                        StatsClear,
  output logic [COUNT_WIDTH-1:0]      EncodedCount,
  output logic [COUNT_WIDTH-1:0]      ErrorCount
`endif
);

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  logic                        out_valid;
  logic [INSTRUCTION_SIZE-1:0] out_word;
  logic                        out_err;
  logic                        skid_valid;
  logic [INSTRUCTION_SIZE-1:0] skid_word;
  logic                        skid_err;

  logic [INSTRUCTION_SIZE-1:0] enc_word;
  logic                        enc_err;
  logic signed [IMMEDIATE_SIZE-1:0] simm;
  logic                        accept;
  logic                        transfer;

  assign simm     = Immediate;
  assign accept   = InValid && InReady;
  assign transfer = out_valid && OutReady;

  assign InReady     = !skid_valid;
  assign OutValid    = out_valid;
  assign Instruction = out_word;
  assign EncError    = out_err;

  // Out-of-range immediates still pack their truncated bits; only the error flag reports the problem.
  always_comb begin
    enc_word = '0;
    enc_err  = 1'b0;
    case (Format)
      FMT_R: begin
        enc_word = {Funct7, Rs2, Rs1, Funct3, Rd, Opcode};
      end
      FMT_I: begin
        enc_word = {Immediate[11:0], Rs1, Funct3, Rd, Opcode};
        enc_err  = (simm < -2048) || (simm > 2047);
      end
      FMT_S: begin
        enc_word = {Immediate[11:5], Rs2, Rs1, Funct3, Immediate[4:0], Opcode};
        enc_err  = (simm < -2048) || (simm > 2047);
      end
      FMT_B: begin
        enc_word = {Immediate[12], Immediate[10:5], Rs2, Rs1, Funct3,
                    Immediate[4:1], Immediate[11], Opcode};
        enc_err  = (simm < -4096) || (simm > 4094) || Immediate[0];
      end
      FMT_U: begin
        enc_word = {Immediate[31:12], Rd, Opcode};
        enc_err  = (Immediate[11:0] != 12'd0);
      end
      FMT_J: begin
        enc_word = {Immediate[20], Immediate[10:1], Immediate[11], Immediate[19:12], Rd, Opcode};
        enc_err  = (simm < -1048576) || (simm > 1048574) || Immediate[0];
      end
      default: begin
        enc_word = 32'h0000_0013;
        enc_err  = 1'b1;
      end
    endcase
  end

  // The output register refills from the skid first so ordering is preserved; the skid only
  // captures when the output is occupied and stalled.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      out_valid  <= 1'b0;
      out_word   <= '0;
      out_err    <= 1'b0;
      skid_valid <= 1'b0;
      skid_word  <= '0;
      skid_err   <= 1'b0;
    end else begin
      if (!out_valid || OutReady) begin
        if (skid_valid) begin
          out_valid  <= 1'b1;
          out_word   <= skid_word;
          out_err    <= skid_err;
          skid_valid <= 1'b0;
        end else if (accept) begin
          out_valid <= 1'b1;
          out_word  <= enc_word;
          out_err   <= enc_err;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (accept) begin
        skid_valid <= 1'b1;
        skid_word  <= enc_word;
        skid_err   <= enc_err;
      end
    end
  end

`ifdef ENCODER_STATS_EN
  // Saturating counters; a clear request wins over any increment in the same cycle.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      EncodedCount <= '0;
      ErrorCount   <= '0;
    end else if (StatsClear) begin
      EncodedCount <= '0;
      ErrorCount   <= '0;
    end else if (transfer) begin
      if (EncodedCount != '1) EncodedCount <= EncodedCount + 1'b1;
      if (out_err && (ErrorCount != '1)) ErrorCount <= ErrorCount + 1'b1;
    end
  end
`endif

endmodule
